// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the I-cache and the
// D-cache. One line transfer at a time; the winner's command, address and
// writeback line are latched at grant and the memory response is routed back
// to the winner only.
//
// Build option: ARB_ROUND_ROBIN_EN. When defined, the arbiter alternates
// between the two caches if both request in the same IDLE cycle. When
// undefined, the D-cache always has priority over the I-cache.
module cache_arbiter #(
    parameter int ADDR_W = 16,
    parameter int LINE_W = 128
) (
    input  logic              clk,
    input  logic              rst,
    // I-cache side
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    // D-cache side
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    // memory side
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp,
    // status
    output logic              arb_busy
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SERVE_I = 2'd1;
    localparam logic [1:0] SERVE_D = 2'd2;

    // last_grant encoding: 0 = I-cache, 1 = D-cache
    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] addr_latch;
    logic [LINE_W-1:0] wdata_latch;
    logic              op_write;
    logic              last_grant;

    logic              d_req;
    logic              grant_i;
    logic              grant_d;
    logic              done;

    assign d_req = d_read | d_write;

    // Choose a winner in IDLE; only meaningful while state == IDLE.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
`ifdef ARB_ROUND_ROBIN_EN
            if (d_req && i_read) begin
                // Both waiting: hand the port to whoever did not have it last.
                grant_d = (last_grant == GRANT_I);
                grant_i = (last_grant == GRANT_D);
            end else begin
                grant_d = d_req;
                grant_i = i_read;
            end
`else
            // A stalled MEM stage has to drain before fetch may proceed.
            grant_d = d_req;
            grant_i = i_read & ~d_req;
`endif
        end
    end

    // A transfer finishes on the memory's completion pulse while serving.
    assign done = (state != IDLE) && pmem_resp;

    // Next-state logic: IDLE -> SERVE_x on grant, SERVE_x -> IDLE on completion.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_next = SERVE_D;
                else if (grant_i) state_next = SERVE_I;
            end
            SERVE_I, SERVE_D: begin
                if (pmem_resp) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register and grant-time latches; cleared on completion so the
    // memory-side outputs read as zero whenever the arbiter is idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr_latch  <= '0;
            wdata_latch <= '0;
            op_write    <= 1'b0;
            last_grant  <= GRANT_I;
        end else begin
            state <= state_next;
            if (grant_d) begin
                addr_latch  <= d_address;
                wdata_latch <= d_wdata;
                // Write wins when both d_read and d_write are raised.
                op_write    <= d_write;
                last_grant  <= GRANT_D;
            end else if (grant_i) begin
                addr_latch  <= i_address;
                wdata_latch <= '0;
                op_write    <= 1'b0;
                last_grant  <= GRANT_I;
            end else if (done) begin
                addr_latch  <= '0;
                wdata_latch <= '0;
                op_write    <= 1'b0;
            end
        end
    end

    // Memory-side drive comes purely from the latches while serving.
    always_comb begin
        pmem_read    = (state != IDLE) && !op_write;
        pmem_write   = (state != IDLE) && op_write;
        pmem_address = addr_latch;
        pmem_wdata   = wdata_latch;
        arb_busy     = (state != IDLE);
    end

    // Route the completion back to the winner only; the other side sees zeros.
    always_comb begin
        i_resp  = (state == SERVE_I) && pmem_resp;
        d_resp  = (state == SERVE_D) && pmem_resp;
        i_rdata = i_resp ? pmem_rdata : '0;
        d_rdata = d_resp ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed testbench for cache_arbiter. Honours ARB_ROUND_ROBIN_EN when the
// same macro is defined for the bench build.
module tb_cache_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 128;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_read;
    logic [ADDR_W-1:0] i_address;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read;
    logic              d_write;
    logic [ADDR_W-1:0] d_address;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic              arb_busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cache_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .arb_busy     (arb_busy)
    );

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_addr(input string tag, input logic [ADDR_W-1:0] obs, input logic [ADDR_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle-side expectations: nothing on the memory port, no responses.
    task automatic chk_quiet(input string tag);
        chk_bit({tag, ".busy"},   arb_busy,   1'b0);
        chk_bit({tag, ".pread"},  pmem_read,  1'b0);
        chk_bit({tag, ".pwrite"}, pmem_write, 1'b0);
        chk_bit({tag, ".iresp"},  i_resp,     1'b0);
        chk_bit({tag, ".dresp"},  d_resp,     1'b0);
    endtask

    logic [LINE_W-1:0] line_a5;
    logic [LINE_W-1:0] line_dead;
    logic [LINE_W-1:0] line_x;
    logic              first_is_d;

    initial begin
        line_a5   = {16{8'hA5}};
        line_dead = {4{32'hDEADBEEF}};
        line_x    = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

        rst = 1'b1; i_read = 0; i_address = '0; d_read = 0; d_write = 0;
        d_address = '0; d_wdata = '0; pmem_rdata = '0; pmem_resp = 0;
        #1;
        // ---- reset state
        chk_quiet("reset");
        chk_addr("reset.paddr", pmem_address, 16'h0000);
        chk_line("reset.pwdata", pmem_wdata, '0);
        chk_line("reset.irdata", i_rdata, '0);
        chk_line("reset.drdata", d_rdata, '0);
        step(); step();
        rst = 1'b0;
        step();
        $display("txn reset done");

        // ---- single I read, memory answers on the third serving cycle
        i_read = 1; i_address = 16'h0040;
        #1;
        chk_bit("iread.cycN.pread", pmem_read, 1'b0);
        step();
        chk_bit("iread.pread", pmem_read, 1'b1);
        chk_bit("iread.pwrite", pmem_write, 1'b0);
        chk_addr("iread.paddr", pmem_address, 16'h0040);
        chk_bit("iread.busy", arb_busy, 1'b1);
        i_address = 16'hFFFF;          // must be ignored while serving
        step();
        chk_addr("iread.hold_addr", pmem_address, 16'h0040);
        chk_bit("iread.early_iresp", i_resp, 1'b0);
        step();
        pmem_resp = 1; pmem_rdata = line_a5;
        #1;
        chk_bit("iread.iresp", i_resp, 1'b1);
        chk_line("iread.irdata", i_rdata, line_a5);
        chk_bit("iread.dresp", d_resp, 1'b0);
        chk_line("iread.drdata", d_rdata, '0);
        step();
        i_read = 0; pmem_resp = 0; pmem_rdata = '0;
        #1;
        chk_quiet("iread.after");
        $display("txn single I read addr=0040");
        step();

        // ---- D writeback
        d_write = 1; d_address = 16'h1230; d_wdata = line_dead;
        step();
        chk_bit("wb.pwrite", pmem_write, 1'b1);
        chk_bit("wb.pread", pmem_read, 1'b0);
        chk_addr("wb.paddr", pmem_address, 16'h1230);
        chk_line("wb.pwdata", pmem_wdata, line_dead);
        step();
        pmem_resp = 1;
        #1;
        chk_bit("wb.dresp", d_resp, 1'b1);
        chk_bit("wb.iresp", i_resp, 1'b0);
        step();
        d_write = 0; pmem_resp = 0;
        #1;
        chk_quiet("wb.after");
        $display("txn D writeback addr=1230");
        step();

        // ---- spurious pmem_resp in IDLE
        pmem_resp = 1; pmem_rdata = line_x;
        #1;
        chk_quiet("spur");
        chk_line("spur.irdata", i_rdata, '0);
        chk_line("spur.drdata", d_rdata, '0);
        step();
        pmem_resp = 0; pmem_rdata = '0;
        $display("txn spurious pmem_resp in IDLE");
        step();

        // ---- simultaneous requests; last grant was D
`ifdef ARB_ROUND_ROBIN_EN
        first_is_d = 1'b0;
`else
        first_is_d = 1'b1;
`endif
        i_read = 1; i_address = 16'h0100;
        d_read = 1; d_address = 16'h2000;
        for (int k = 0; k < 2; k++) begin
            logic serve_d;
            serve_d = (k == 0) ? first_is_d : !first_is_d;
            step();
            chk_bit("sim.busy", arb_busy, 1'b1);
            chk_bit("sim.pread", pmem_read, 1'b1);
            chk_addr("sim.paddr", pmem_address, serve_d ? 16'h2000 : 16'h0100);
            pmem_resp = 1; pmem_rdata = line_x;
            #1;
            chk_bit("sim.dresp", d_resp, serve_d);
            chk_bit("sim.iresp", i_resp, !serve_d);
            chk_line("sim.rdata", serve_d ? d_rdata : i_rdata, line_x);
            step();
            pmem_resp = 0; pmem_rdata = '0;
            if (serve_d) d_read = 0; else i_read = 0;
            #1;
            // mandatory idle cycle between transfers
            chk_bit("sim.gap_busy", arb_busy, 1'b0);
            chk_bit("sim.gap_pread", pmem_read, 1'b0);
            $display("txn simultaneous slot=%0d served=%s", k, serve_d ? "D" : "I");
        end
        step();
        chk_quiet("sim.done");

        // ---- d_read and d_write together -> write only
        d_read = 1; d_write = 1; d_address = 16'h4440; d_wdata = line_x;
        step();
        chk_bit("rw.pwrite", pmem_write, 1'b1);
        chk_bit("rw.pread", pmem_read, 1'b0);
        chk_line("rw.pwdata", pmem_wdata, line_x);
        pmem_resp = 1;
        #1;
        chk_bit("rw.dresp", d_resp, 1'b1);
        step();
        d_read = 0; d_write = 0; pmem_resp = 0;
        $display("txn d_read+d_write treated as write");
        step();

        // ---- reset two cycles into SERVE_D
        d_read = 1; d_address = 16'h3000;
        step();
        chk_bit("rst.pread_pre", pmem_read, 1'b1);
        step();
        rst = 1; pmem_resp = 1; pmem_rdata = line_a5;
        #1;
        chk_quiet("rst.mid");
        chk_addr("rst.paddr", pmem_address, 16'h0000);
        chk_line("rst.drdata", d_rdata, '0);
        step();
        rst = 0; pmem_resp = 0; pmem_rdata = '0;
        #1;
        chk_bit("rst.rel_busy", arb_busy, 1'b0);
        step();
        chk_bit("rst.regrant_pread", pmem_read, 1'b1);
        chk_addr("rst.regrant_paddr", pmem_address, 16'h3000);
        pmem_resp = 1;
        #1;
        chk_bit("rst.regrant_dresp", d_resp, 1'b1);
        step();
        d_read = 0; pmem_resp = 0;
        #1;
        chk_quiet("rst.end");
        $display("txn reset mid-transfer and re-grant");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
- Shares the single physical-memory port between the I-cache and D-cache of the pipelined LC-3b core.
- Grants one line transfer at a time and latches the winner's command, address and write line.
- Routes the memory response back to the winner only.
- Sits between the split L1 caches and pmem (or L2); the control_rom-driven datapath stalls on cache resp as before.

Parameters:
- ADDR_W, 16, byte address width
- LINE_W, 128, cache line width in bits

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- i_read  in  1  I-cache line read request; held high until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  line returned to I-cache
- i_resp  out  1  one-cycle completion pulse to I-cache
- d_read  in  1  D-cache line read (fill) request
- d_write  in  1  D-cache line write (writeback) request
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  writeback line
- d_rdata  out  LINE_W  line returned to D-cache
- d_resp  out  1  one-cycle completion pulse to D-cache
- pmem_read  out  1  memory read strobe
- pmem_write  out  1  memory write strobe
- pmem_address  out  ADDR_W  latched address
- pmem_wdata  out  LINE_W  latched writeback line
- pmem_rdata  in  LINE_W  memory read line
- pmem_resp  in  1  memory completion pulse
- arb_busy  out  1  high in any non-IDLE state

Behaviour:
- Interface (already decided): one clock (clk); reset (rst) is asynchronous and active-high.
- States: IDLE, SERVE_I, SERVE_D.
- Reset: state=IDLE; all outputs 0, including latches, last_grant and pmem_address/pmem_wdata.
- IDLE arbitration, evaluated each cycle:
  - D request (d_read|d_write) wins over i_read (a stalled MEM stage must drain before fetch).
  - On grant, at the clock edge: latch address, op (write if d_write, else read), d_wdata, and last_grant; go to SERVE_x.
  - Grant latency: request seen in cycle N -> pmem strobe asserted from cycle N+1.
- d_read and d_write both high: treated as a write; d_read is ignored.
- SERVE_x:
  - Drive pmem_read or pmem_write from the latched op, with pmem_address/pmem_wdata from the latches.
  - Requester input changes are ignored while serving.
- Completion: when pmem_resp=1 in SERVE_x:
  - x_resp=1 in the same cycle (combinational); x_rdata=pmem_rdata.
  - The other side's resp stays 0.
  - Next state is IDLE, with strobes low for at least that one cycle.
- Responses: i_rdata and d_rdata are pmem_rdata when the matching resp is high, else 0. The non-granted side never sees resp.
- Back-to-back: a request held into the cycle after resp is treated as a new request (IDLE re-arbitrates). Minimum of one idle cycle between transfers.
- pmem_resp outside SERVE_x: ignored, no resp generated.
- Reset mid-transfer: immediate IDLE, strobes drop, no resp is issued, latches cleared.
- No request in IDLE: stay in IDLE, outputs 0.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both sides request in IDLE, grant the side that is not last_grant (alternating). A single requester is always granted.
- Undefined: fixed D-over-I priority as above; last_grant is kept but unused.

Test Plan:
- Single I read: i_read=1, i_address=16'h0040; pmem_resp after 3 cycles with rdata=128'hA5... -> pmem_read=1 with address 16'h0040 from the next cycle; i_resp=1 with i_rdata=128'hA5... for exactly one cycle; d_resp=0 throughout; arb_busy=0 on the following cycle.
- Writeback: d_write=1, d_address=16'h1230, d_wdata=128'hDEADBEEF... -> pmem_write=1, pmem_wdata matches, pmem_read=0; d_resp pulses on pmem_resp.
- Simultaneous i_read and d_read (macro undefined), both held -> D served first, then one IDLE cycle, then I served; each resp exactly once.
- Same setup with ARB_ROUND_ROBIN_EN defined and last_grant=D -> I served first.
- Spurious/illegal inputs: pmem_resp pulsed in IDLE -> no resp. d_read=d_write=1 -> pmem_write only.
- rst asserted two cycles into SERVE_D -> same-cycle IDLE, pmem strobes 0, no d_resp. After release, a held d_read is re-granted.
